uart_rx_tlb: RTL and testbench

UART_RX_TLB -- requirements
Module: uart_rx_tlb

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rx_tlb_if.sv | 45 ++++
 rtl/sync_bit.sv | 35 +++
 rtl/uart_rx_tlb.sv | 164 ++++++++++++++++
 tb/tb_uart_rx_tlb.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path: receiver FSM state encoding,
// the default bit period and the data width.
// No ports (package).
// ---------------------------------------------------------------------------
package uart_pkg;

  // 100 MHz system clock / 115200 baud
  localparam int CLKS_PER_BIT_DEFAULT = 868;
  localparam int UART_DATA_W          = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_tlb_if.sv
// ---------------------------------------------------------------------------
// uart_rx_tlb_if
// Bundles the serial line, the command-FIFO write port and the status pulses
// of the UART receiver.
//   rx_data          serial line, idle high, asynchronous to clk
//   rx_fifo_wr_data  received byte
//   rx_fifo_wr_en    one-cycle write strobe for rx_fifo_wr_data
//   rx_fifo_full     FIFO cannot accept a write this cycle
//   rx_frame_err     one-cycle pulse: stop bit sampled low
//   rx_overrun       one-cycle pulse: good byte dropped, FIFO full
//   rx_busy          receiver FSM not idle
// Modports: slave = receiver side, master = line driver / FIFO side.
// ---------------------------------------------------------------------------
interface uart_rx_tlb_if;
  import uart_pkg::*;

  logic                   rx_data;
  logic [UART_DATA_W-1:0] rx_fifo_wr_data;
  logic                   rx_fifo_wr_en;
  logic                   rx_fifo_full;
  logic                   rx_frame_err;
  logic                   rx_overrun;
  logic                   rx_busy;

  modport slave (
    input  rx_data,
    input  rx_fifo_full,
    output rx_fifo_wr_data,
    output rx_fifo_wr_en,
    output rx_frame_err,
    output rx_overrun,
    output rx_busy
  );

  modport master (
    output rx_data,
    output rx_fifo_full,
    input  rx_fifo_wr_data,
    input  rx_fifo_wr_en,
    input  rx_frame_err,
    input  rx_overrun,
    input  rx_busy
  );

endinterface

// File: rtl/sync_bit.sv
// ---------------------------------------------------------------------------
// sync_bit
// Multi-flop synchronizer for a single asynchronous bit. Flops reset to 1 so
// an idle-high serial line looks idle straight out of reset.
//   clk   system clock
//   rst   asynchronous active-high reset
//   i_d   asynchronous input
//   o_q   synchronized output (SYNC_STAGES cycles of latency)
// ---------------------------------------------------------------------------
module sync_bit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_sync;

  // NOTE: non-blocking (<=) in clocked blocks so every flop samples the
  // pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: reset to the idle level (1), not 0, so leaving reset never
      // presents a false start bit to the receiver.
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_tlb.sv
// ---------------------------------------------------------------------------
// uart_rx_tlb
// 8N1 UART receiver feeding a command FIFO. The line is synchronized, the
// start bit is confirmed at its middle, data and stop bits are sampled at
// their middles, and the result is reported as a single-cycle write,
// framing-error or overrun pulse.
//   clk  system clock (rising edge)
//   rst  asynchronous active-high reset
//   bus  uart_rx_tlb_if.slave (serial line, FIFO write port, status)
// ---------------------------------------------------------------------------
module uart_rx_tlb
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int SYNC_STAGES  = 2
) (
  input  logic          clk,
  input  logic          rst,
  uart_rx_tlb_if.slave  bus
);

  localparam int TIMER_W = $clog2(CLKS_PER_BIT);
  localparam logic [TIMER_W-1:0] HALF_BIT_M1 = TIMER_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TIMER_W-1:0] FULL_BIT_M1 = TIMER_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]         LAST_IDX    = 3'(UART_DATA_W - 1);

  logic                   w_rx_s;

  uart_rx_state_t         r_state,    w_state_nxt;
  logic [TIMER_W-1:0]     r_timer,    w_timer_nxt;
  logic [2:0]             r_idx,      w_idx_nxt;
  logic [UART_DATA_W-1:0] r_shift,    w_shift_nxt;
  logic [UART_DATA_W-1:0] r_wr_data,  w_wr_data_nxt;
  logic                   r_wr_en,    w_wr_en_nxt;
  logic                   r_frame_err, w_frame_err_nxt;
  logic                   r_overrun,  w_overrun_nxt;
  logic                   w_bit_end;
  logic [TIMER_W-1:0]     w_timer_inc;

  sync_bit #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (bus.rx_data),
    .o_q (w_rx_s)
  );

  assign w_bit_end   = (r_timer == FULL_BIT_M1);
  assign w_timer_inc = r_timer + TIMER_W'(1);

  // State register and all datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_timer     <= '0;
      r_idx       <= '0;
      r_shift     <= '0;
      r_wr_data   <= '0;
      r_wr_en     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_timer     <= w_timer_nxt;
      r_idx       <= w_idx_nxt;
      r_shift     <= w_shift_nxt;
      r_wr_data   <= w_wr_data_nxt;
      r_wr_en     <= w_wr_en_nxt;
      r_frame_err <= w_frame_err_nxt;
      r_overrun   <= w_overrun_nxt;
    end
  end

  // Next-state and next-datapath logic
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // skips an assignment would otherwise infer a latch.
    w_state_nxt     = r_state;
    w_timer_nxt     = r_timer;
    w_idx_nxt       = r_idx;
    w_shift_nxt     = r_shift;
    w_wr_data_nxt   = r_wr_data;
    w_wr_en_nxt     = 1'b0;
    w_frame_err_nxt = 1'b0;
    w_overrun_nxt   = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        w_timer_nxt = '0;
        if (!w_rx_s) begin
          w_state_nxt = S_START;
        end
      end

      S_START: begin
        // Confirm the start bit at its middle; a high line here was a glitch.
        if (r_timer == HALF_BIT_M1) begin
          w_timer_nxt = '0;
          w_idx_nxt   = '0;
          w_state_nxt = w_rx_s ? S_IDLE : S_DATA;
        end else begin
          w_timer_nxt = w_timer_inc;
        end
      end

      S_DATA: begin
        // Timer was cleared mid start bit, so each wrap lands mid data bit.
        if (w_bit_end) begin
          w_timer_nxt        = '0;
          w_shift_nxt[r_idx] = w_rx_s;
          w_idx_nxt          = r_idx + 3'd1;
          if (r_idx == LAST_IDX) begin
            w_state_nxt = S_STOP;
          end
        end else begin
          w_timer_nxt = w_timer_inc;
        end
      end

      S_STOP: begin
        // Sample mid stop bit and return early so a back-to-back start edge
        // half a bit later is still seen from IDLE.
        if (w_bit_end) begin
          w_timer_nxt = '0;
          if (w_rx_s) begin
            w_state_nxt = S_IDLE;
            if (bus.rx_fifo_full) begin
              w_overrun_nxt = 1'b1;
            end else begin
              w_wr_en_nxt   = 1'b1;
              w_wr_data_nxt = r_shift;
            end
          end else begin
            w_frame_err_nxt = 1'b1;
            w_state_nxt     = S_BREAK;
          end
        end else begin
          w_timer_nxt = w_timer_inc;
        end
      end

      S_BREAK: begin
        // Wait out a held-low line (break) before hunting for a new start.
        w_timer_nxt = '0;
        if (w_rx_s) begin
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_timer_nxt = '0;
      end
    endcase
  end

  assign bus.rx_fifo_wr_data = r_wr_data;
  assign bus.rx_fifo_wr_en   = r_wr_en;
  assign bus.rx_frame_err    = r_frame_err;
  assign bus.rx_overrun      = r_overrun;
  assign bus.rx_busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_tlb.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_tlb
// Self-checking bench for uart_rx_tlb with CLKS_PER_BIT=16. Each scenario
// task pushes the events it expects (write/frame error/overrun) into a
// scoreboard queue; a negedge monitor pops and compares every strobe the
// DUT produces.
// ---------------------------------------------------------------------------
module tb_uart_rx_tlb;
  import uart_pkg::*;

  localparam int CPB        = 16;
  localparam int SYNC       = 2;
  localparam int CLK_PERIOD = 10;

  typedef enum int {EV_WRITE, EV_FERR, EV_OVR} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [7:0] data;
  } ev_t;

  logic clk;
  logic rst;

  uart_rx_tlb_if bus ();

  uart_rx_tlb #(
    .CLKS_PER_BIT (CPB),
    .SYNC_STAGES  (SYNC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  ev_t         exp_q[$];
  int unsigned wr_cycles[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned cyc = 0;
  bit          prev_pulse = 1'b0;
  logic [2:0]  mon_pulses;
  ev_kind_t    mon_kind;
  ev_t         mon_e;

  initial begin
    clk = 1'b0;
    forever #(CLK_PERIOD / 2) clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every strobe must match the head of exp_q.
  always @(negedge clk) begin
    if (rst) begin
      prev_pulse = 1'b0;
    end else begin
      mon_pulses = {bus.rx_fifo_wr_en, bus.rx_frame_err, bus.rx_overrun};
      if (mon_pulses != 3'b000) begin
        n_checks++;
        if ($countones(mon_pulses) != 1 || prev_pulse) begin
          n_errors++;
          $display("FAIL strobe_exclusive: cycle %0d strobes(wr,ferr,ovr)=%b prev=%0b, required exactly one and none previous cycle",
                   cyc, mon_pulses, prev_pulse);
        end
        if (bus.rx_fifo_wr_en)      mon_kind = EV_WRITE;
        else if (bus.rx_frame_err)  mon_kind = EV_FERR;
        else                        mon_kind = EV_OVR;
        if (mon_kind == EV_WRITE) wr_cycles.push_back(cyc);
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_event: cycle %0d got %s data=%02h, required no event",
                   cyc, mon_kind.name(), bus.rx_fifo_wr_data);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.kind !== mon_kind ||
              (mon_kind == EV_WRITE && bus.rx_fifo_wr_data !== mon_e.data)) begin
            n_errors++;
            $display("FAIL event_match: cycle %0d got %s data=%02h, required %s data=%02h",
                     cyc, mon_kind.name(), bus.rx_fifo_wr_data, mon_e.kind.name(), mon_e.data);
          end
        end
      end
      prev_pulse = (mon_pulses != 3'b000);
    end
  end

  initial begin
    #(200_000 * CLK_PERIOD);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_bits(input logic v, input int n);
    bus.rx_data = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_v);
    drive_bits(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_bits(b[i], CPB);
    drive_bits(stop_v, CPB);
  endtask

  task automatic push_ev(input ev_kind_t k, input logic [7:0] d);
    ev_t e;
    e.kind = k;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic expect_drained(input string name);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL %s_drained: %0d expected events never seen, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.rx_data = 1'b1;
    bus.rx_fifo_full = 1'b0;
    repeat (3) @(negedge clk);
    n_checks += 5;
    if (bus.rx_fifo_wr_data !== 8'h00) begin n_errors++; $display("FAIL reset_wr_data: got %02h, required 00", bus.rx_fifo_wr_data); end
    if (bus.rx_fifo_wr_en !== 1'b0)    begin n_errors++; $display("FAIL reset_wr_en: got %b, required 0", bus.rx_fifo_wr_en); end
    if (bus.rx_frame_err !== 1'b0)     begin n_errors++; $display("FAIL reset_frame_err: got %b, required 0", bus.rx_frame_err); end
    if (bus.rx_overrun !== 1'b0)       begin n_errors++; $display("FAIL reset_overrun: got %b, required 0", bus.rx_overrun); end
    if (bus.rx_busy !== 1'b0)          begin n_errors++; $display("FAIL reset_busy: got %b, required 0", bus.rx_busy); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (bus.rx_busy !== 1'b0) begin n_errors++; $display("FAIL post_reset_busy: got %b, required 0", bus.rx_busy); end
  endtask

  task automatic test_good_byte();
    push_ev(EV_WRITE, 8'hA5);
    send_byte(8'hA5, 1'b1);
    drive_bits(1'b1, CPB);
    expect_drained("good_byte");
    n_checks += 2;
    if (bus.rx_fifo_wr_data !== 8'hA5) begin n_errors++; $display("FAIL good_byte_hold: got %02h, required A5", bus.rx_fifo_wr_data); end
    if (bus.rx_busy !== 1'b0)          begin n_errors++; $display("FAIL good_byte_idle: busy got %b, required 0", bus.rx_busy); end
  endtask

  task automatic test_glitch();
    drive_bits(1'b0, CPB / 4);
    n_checks++;
    if (bus.rx_busy !== 1'b1) begin n_errors++; $display("FAIL glitch_detect: busy got %b, required 1", bus.rx_busy); end
    drive_bits(1'b1, 12 - CPB / 4);
    n_checks++;
    if (bus.rx_busy !== 1'b0) begin n_errors++; $display("FAIL glitch_idle: busy got %b 12 cycles after glitch, required 0", bus.rx_busy); end
    drive_bits(1'b1, CPB);
    expect_drained("glitch");
  endtask

  task automatic test_frame_err();
    push_ev(EV_FERR, 8'h00);
    send_byte(8'h3C, 1'b0);
    drive_bits(1'b0, 3 * CPB);
    n_checks += 2;
    if (bus.rx_busy !== 1'b1)          begin n_errors++; $display("FAIL break_busy: got %b while line low, required 1", bus.rx_busy); end
    if (bus.rx_fifo_wr_data !== 8'hA5) begin n_errors++; $display("FAIL break_no_write: wr_data got %02h, required A5", bus.rx_fifo_wr_data); end
    drive_bits(1'b1, SYNC + 2);
    n_checks++;
    if (bus.rx_busy !== 1'b0) begin n_errors++; $display("FAIL break_release: busy got %b after line rose, required 0", bus.rx_busy); end
    drive_bits(1'b1, CPB);
    expect_drained("frame_err");
  endtask

  task automatic test_overrun();
    bus.rx_fifo_full = 1'b1;
    push_ev(EV_OVR, 8'h00);
    send_byte(8'h55, 1'b1);
    drive_bits(1'b1, CPB);
    bus.rx_fifo_full = 1'b0;
    expect_drained("overrun");
    n_checks++;
    if (bus.rx_fifo_wr_data !== 8'hA5) begin n_errors++; $display("FAIL overrun_no_write: wr_data got %02h, required A5", bus.rx_fifo_wr_data); end
    push_ev(EV_WRITE, 8'h55);
    send_byte(8'h55, 1'b1);
    drive_bits(1'b1, CPB);
    expect_drained("overrun_retry");
  endtask

  task automatic test_back_to_back();
    wr_cycles.delete();
    push_ev(EV_WRITE, 8'h00);
    push_ev(EV_WRITE, 8'hFF);
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    drive_bits(1'b1, CPB);
    expect_drained("back_to_back");
    n_checks++;
    if (wr_cycles.size() != 2) begin
      n_errors++;
      $display("FAIL b2b_count: got %0d writes, required 2", wr_cycles.size());
    end else begin
      n_checks++;
      if (wr_cycles[1] - wr_cycles[0] != 10 * CPB) begin
        n_errors++;
        $display("FAIL b2b_spacing: got %0d cycles, required %0d", wr_cycles[1] - wr_cycles[0], 10 * CPB);
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] b;
    b = 8'h81;
    drive_bits(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive_bits(b[i], CPB);
    drive_bits(b[4], CPB / 2);
    rst = 1'b1;
    #1;
    n_checks += 5;
    if (bus.rx_fifo_wr_data !== 8'h00) begin n_errors++; $display("FAIL midrst_wr_data: got %02h, required 00", bus.rx_fifo_wr_data); end
    if (bus.rx_fifo_wr_en !== 1'b0)    begin n_errors++; $display("FAIL midrst_wr_en: got %b, required 0", bus.rx_fifo_wr_en); end
    if (bus.rx_frame_err !== 1'b0)     begin n_errors++; $display("FAIL midrst_frame_err: got %b, required 0", bus.rx_frame_err); end
    if (bus.rx_overrun !== 1'b0)       begin n_errors++; $display("FAIL midrst_overrun: got %b, required 0", bus.rx_overrun); end
    if (bus.rx_busy !== 1'b0)          begin n_errors++; $display("FAIL midrst_busy: got %b, required 0", bus.rx_busy); end
    @(negedge clk);
    bus.rx_data = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (CPB) @(negedge clk);
    n_checks++;
    if (bus.rx_busy !== 1'b0) begin n_errors++; $display("FAIL midrst_idle: busy got %b after release, required 0", bus.rx_busy); end
    push_ev(EV_WRITE, 8'h7E);
    send_byte(8'h7E, 1'b1);
    drive_bits(1'b1, CPB);
    expect_drained("reset_midframe");
    n_checks++;
    if (bus.rx_fifo_wr_data !== 8'h7E) begin n_errors++; $display("FAIL midrst_data: got %02h, required 7E", bus.rx_fifo_wr_data); end
  endtask

  initial begin
    rst = 1'b1;
    bus.rx_data = 1'b1;
    bus.rx_fifo_full = 1'b0;
    test_reset();
    test_good_byte();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_back_to_back();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
